axi4_burst_read_responder: RTL and testbench
============================================

# axi4_burst_read_responder

Synthesizable AXI4 read-channel responder (slave) backed by an internal block-RAM word array. It answers the INCR/FIXED bursts issued by the frame-buffer/audio reader master with a programmable DDR-like latency and full-throughput R beats under RREADY backpressure. It is used both as a hardware loopback target in board bring-up and as the DDR stand-in in reader simulations. A backdoor write port preloads the array.

## Interface
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 64, R data width; must be 64, one word per beat
- ID_WIDTH, 1, ARID/RID width
- BASE_ADDR, 32'h81000000, byte address of word 0
- MEM_DEPTH_WORDS, 4096, array depth in 64-bit words, power of two
- LATENCY, 6, cycles between AR handshake and the first-beat fetch, range 0..255

- s00_axi_aclk  in  1  sole clock, rising edge
- s00_axi_reset  in  1  synchronous, active-high reset
- s00_axi_arid  in  ID_WIDTH  burst ID, echoed on RID
- s00_axi_araddr  in  ADDR_WIDTH  byte start address
- s00_axi_arlen  in  8  beats minus one
- s00_axi_arsize  in  3  must be 3'd3
- s00_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake
- s00_axi_rid  out  ID_WIDTH  latched ARID
- s00_axi_rdata  out  DATA_WIDTH  beat data
- s00_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s00_axi_rlast  out  1  final beat
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake
- bd_we  in  1  backdoor write strobe
- bd_addr  in  $clog2(MEM_DEPTH_WORDS)  backdoor word index
- bd_wdata  in  DATA_WIDTH  backdoor data
- busy  out  1  high from AR handshake through the final R handshake

## Operation
- States: IDLE, WAIT, FETCH, DATA. Only one burst is outstanding at a time.
- IDLE: arready=1. On arvalid&&arready, latch id, len, burst, and word index = (araddr-BASE_ADDR)>>3. The low 3 address bits are ignored (the address is aligned down). Go to WAIT with the counter set to LATENCY; with LATENCY=0 go straight to FETCH.
- WAIT: decrement the counter each cycle; when it reaches 1, go to FETCH.
- FETCH: read-enable the RAM at the first beat index. Next state is DATA.
- DATA: rvalid=1; rdata is the RAM output.
  - On each rvalid&&rready that is not the last beat, read-enable the RAM at the next index. The RAM output holds while rready=0, so beats stream back-to-back with no bubble.
  - INCR: index +1 per beat. FIXED: index constant.
  - rlast=1 when the beat counter equals the latched len.
  - Handshake on rlast: go to IDLE, deassert rvalid.
- Error rules, per beat; the burst length is always honored:
  - Beat index < 0 or ≥ MEM_DEPTH_WORDS: rdata=0, rresp=SLVERR.
  - arburst=WRAP or arsize≠3: every beat rresp=SLVERR, rdata=0.
  - Otherwise rresp=OKAY.
- Index arithmetic is ADDR_WIDTH-bit signed. There is no 4 KB-boundary check.
- Backdoor port: writes at any time. The RAM is read-first, so a same-cycle read of the same word returns the old data.

## Timing
- Reset values: arready=0 during reset and 1 in the cycle after; rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, busy=0, state=IDLE. RAM contents are not cleared.
- First rvalid is exactly LATENCY+2 cycles after the AR handshake cycle (8 cycles at the default).
- arready=0 from the cycle after the handshake until the cycle after the last R handshake. A new AR can handshake no sooner than 1 cycle after rlast is accepted.
- rvalid, once high, stays high with stable rdata/rresp/rlast/rid until rready is sampled high (AXI rule).
- arlen=0: a single beat with rlast=1 on that beat.
- Reset asserted mid-burst: on the next edge, rvalid=0 and state=IDLE. The partial burst is abandoned.

## Structure
- Shared package axi4_fbreader_pkg holds:
  - burst-type constants BURST_FIXED, BURST_INCR, BURST_WRAP
  - response constants RESP_OKAY, RESP_SLVERR
  - state enum rsp_state_t {IDLE, WAIT, FETCH, DATA}
- One sub-module, axi4_slave_bram: simple dual-port, read-first RAM. Port A is the backdoor write; port B has read enable and a registered output.
- The top level contains the FSM, latency counter, beat counter and error logic.

## Test plan
- Preload words 0..63 with value=index. Issue INCR araddr=BASE_ADDR, arlen=63, rready=1. Required: first rvalid 8 cycles after the handshake; 64 consecutive beats with data 0..63, all OKAY; rlast only on beat 63.
- Same burst with rready toggling 1010… Required: each beat's data is held until accepted; sequence 0..63; no beat dropped or duplicated.
- FIXED at word 5 (value 5), arlen=3. Required: 4 beats of 5, rlast on the 4th.
- INCR at word MEM_DEPTH_WORDS-2, arlen=3. Required: beats 0..1 OKAY with data; beats 2..3 SLVERR with data 0.
- WRAP burst, arlen=1. Required: 2 beats, both SLVERR. Then araddr=BASE_ADDR+3 (unaligned): data of word 0, OKAY.
- Reset asserted at beat 10 of a 64-beat burst. Required: rvalid=0 the next cycle; after reset, a new arlen=0 burst returns the correct word with the 8-cycle latency.

Source files
------------

// File: rtl/axi4_fbreader_pkg.sv
// rtl/axi4_fbreader_pkg.sv - shared AXI4 read-responder constants and state type
package axi4_fbreader_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_8B     = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FETCH = 2'd2,
    DATA  = 2'd3
  } rsp_state_t;

endpackage

// File: rtl/axi4_slave_bram.sv
// rtl/axi4_slave_bram.sv - simple dual-port read-first RAM, write port A, registered read port B
module axi4_slave_bram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4096,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  a_we,
  input  logic [AW-1:0]         a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_re,
  input  logic [AW-1:0]         b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both ports in one process so a colliding read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
    if (b_re) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/axi4_burst_read_responder.sv
// rtl/axi4_burst_read_responder.sv - AXI4 read responder with programmable latency over a BRAM array
module axi4_burst_read_responder
  import axi4_fbreader_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    ID_WIDTH        = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h8100_0000,
  parameter int                    MEM_DEPTH_WORDS = 4096,
  parameter int                    LATENCY         = 6
) (
  input  logic                               s00_axi_aclk,
  input  logic                               s00_axi_reset,
  input  logic [ID_WIDTH-1:0]                s00_axi_arid,
  input  logic [ADDR_WIDTH-1:0]              s00_axi_araddr,
  input  logic [7:0]                         s00_axi_arlen,
  input  logic [2:0]                         s00_axi_arsize,
  input  logic [1:0]                         s00_axi_arburst,
  input  logic                               s00_axi_arvalid,
  output logic                               s00_axi_arready,
  output logic [ID_WIDTH-1:0]                s00_axi_rid,
  output logic [DATA_WIDTH-1:0]              s00_axi_rdata,
  output logic [1:0]                         s00_axi_rresp,
  output logic                               s00_axi_rlast,
  output logic                               s00_axi_rvalid,
  input  logic                               s00_axi_rready,
  input  logic                               bd_we,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0]              bd_wdata,
  output logic                               busy
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);

  rsp_state_t            state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [1:0]            burst_q, burst_d;
  logic                  burst_err_q, burst_err_d;
  logic                  beat_err_q, beat_err_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  logic                  ar_hs, r_hs, last_beat;
  logic [ADDR_WIDTH-1:0] ar_diff, ar_idx, idx_next;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Negative indices wrap to huge unsigned values, so one compare covers both ends.
  function automatic logic idx_oob(input logic [ADDR_WIDTH-1:0] i);
    return i >= ADDR_WIDTH'(MEM_DEPTH_WORDS);
  endfunction

  assign ar_diff   = s00_axi_araddr - BASE_ADDR;
  assign ar_idx    = $signed(ar_diff) >>> 3;
  assign idx_next  = (burst_q == BURST_INCR) ? idx_q + 1'b1 : idx_q;

  assign s00_axi_arready = (state_q == IDLE) && !s00_axi_reset;
  assign s00_axi_rvalid  = (state_q == DATA);
  assign last_beat       = (beat_q == len_q);
  assign s00_axi_rlast   = s00_axi_rvalid && last_beat;
  assign s00_axi_rresp   = (s00_axi_rvalid && beat_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s00_axi_rdata   = (s00_axi_rvalid && !beat_err_q) ? ram_dout : '0;
  assign s00_axi_rid     = id_q;
  assign ar_hs           = s00_axi_arvalid && s00_axi_arready;
  assign r_hs            = s00_axi_rvalid && s00_axi_rready;
  assign busy            = (state_q != IDLE) || ar_hs;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    len_d       = len_q;
    beat_d      = beat_q;
    burst_d     = burst_q;
    burst_err_d = burst_err_q;
    beat_err_d  = beat_err_q;
    id_d        = id_q;
    idx_d       = idx_q;
    rd_en       = 1'b0;
    rd_addr     = idx_q[AW-1:0];
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          id_d        = s00_axi_arid;
          len_d       = s00_axi_arlen;
          burst_d     = s00_axi_arburst;
          burst_err_d = (s00_axi_arsize != SIZE_8B) ||
                        !((s00_axi_arburst == BURST_FIXED) || (s00_axi_arburst == BURST_INCR));
          idx_d       = ar_idx;
          beat_d      = 8'd0;
          wait_cnt_d  = 8'(LATENCY);
          state_d     = (LATENCY == 0) ? FETCH : WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 8'd1;
        if (wait_cnt_q == 8'd1) state_d = FETCH;
      end
      FETCH: begin
        rd_en      = 1'b1;
        beat_err_d = burst_err_q || idx_oob(idx_q);
        state_d    = DATA;
      end
      DATA: begin
        if (r_hs) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            // Prefetch the next beat on the handshake edge so beats stream without bubbles.
            rd_en      = 1'b1;
            rd_addr    = idx_next[AW-1:0];
            idx_d      = idx_next;
            beat_err_d = burst_err_q || idx_oob(idx_next);
            beat_d     = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      burst_q     <= BURST_INCR;
      burst_err_q <= 1'b0;
      beat_err_q  <= 1'b0;
      id_q        <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      burst_q     <= burst_d;
      burst_err_q <= burst_err_d;
      beat_err_q  <= beat_err_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
    end
  end

  axi4_slave_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH_WORDS),
    .AW         (AW)
  ) u_bram (
    .clk     (s00_axi_aclk),
    .a_we    (bd_we),
    .a_addr  (bd_addr),
    .a_wdata (bd_wdata),
    .b_re    (rd_en),
    .b_addr  (rd_addr),
    .b_rdata (ram_dout)
  );

endmodule

// File: tb/tb_axi4_burst_read_responder.sv
// tb/tb_axi4_burst_read_responder.sv - directed self-checking bench for axi4_burst_read_responder
module tb_axi4_burst_read_responder;

  localparam logic [31:0] BASE  = 32'h8100_0000;
  localparam int          DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [63:0] bd_wdata;
  logic        busy;

  logic [63:0] mem_model [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  axi4_burst_read_responder dut (
    .s00_axi_aclk    (clk),
    .s00_axi_reset   (reset),
    .s00_axi_arid    (arid),
    .s00_axi_araddr  (araddr),
    .s00_axi_arlen   (arlen),
    .s00_axi_arsize  (arsize),
    .s00_axi_arburst (arburst),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rid     (rid),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rlast   (rlast),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .bd_we           (bd_we),
    .bd_addr         (bd_addr),
    .bd_wdata        (bd_wdata),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input int idx, input logic [63:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = idx[11:0]; bd_wdata = val;
    mem_model[idx] = val;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic id, input bit toggle,
                           input int abort_at);
    logic [31:0] diff;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    int cur, cyc, beat, guard;
    bit rr, err_all, bad;
    diff    = addr - BASE;
    cur     = $signed(diff) >>> 3;
    err_all = (burst == 2'b10) || (size != 3'd3);
    @(negedge clk);
    cyc = 0;
    while (arready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("ar_ready", {63'd0, arready}, 64'd1);
    arvalid = 1'b1; araddr = addr; arlen = len[7:0];
    arsize = size; arburst = burst; arid = id;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    chk("ar_closed", {63'd0, arready}, 64'd0);
    chk("busy_burst", {63'd0, busy}, 64'd1);
    cyc = 1;
    while (rvalid !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_latency", 64'(cyc), 64'd8);
    beat  = 0;
    guard = 0;
    while (beat <= len && guard < 1000) begin
      if (beat == abort_at) begin
        rready = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rvalid", {63'd0, rvalid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_arready", {63'd0, arready}, 64'd1);
        return;
      end
      rr     = toggle ? (guard % 2 == 0) : 1'b1;
      rready = rr;
      bad    = err_all || cur < 0 || cur >= DEPTH;
      exp_d  = 64'd0;
      if (!bad) exp_d = mem_model[cur];
      exp_r  = bad ? 2'b10 : 2'b00;
      chk("rvalid_held", {63'd0, rvalid}, 64'd1);
      chk("rdata", rdata, exp_d);
      chk("rresp", {62'd0, rresp}, {62'd0, exp_r});
      chk("rlast", {63'd0, rlast}, {63'd0, beat == len});
      chk("rid", {63'd0, rid}, {63'd0, id});
      if (rr) begin
        beat++;
        if (burst == 2'b01) cur++;
      end
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    rready = 1'b0;
    chk("beat_count", 64'(beat), 64'(len + 1));
    chk("done_rvalid", {63'd0, rvalid}, 64'd0);
    chk("done_arready", {63'd0, arready}, 64'd1);
    chk("done_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01;
    arvalid = 1'b0; rready = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_arready", {63'd0, arready}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rlast", {63'd0, rlast}, 64'd0);
    chk("rst_rresp", {62'd0, rresp}, 64'd0);
    chk("rst_rid", {63'd0, rid}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", {63'd0, arready}, 64'd1);

    for (int i = 0; i < 64; i++) bd_write(i, 64'(i));
    bd_write(DEPTH - 2, 64'hDEAD_BEEF_0000_0FFE);
    bd_write(DEPTH - 1, 64'hDEAD_BEEF_0000_0FFF);

    run_burst(BASE, 63, 2'b01, 3'd3, 1'b1, 1'b0, -1);
    run_burst(BASE, 63, 2'b01, 3'd3, 1'b0, 1'b1, -1);
    run_burst(BASE + 32'd40, 3, 2'b00, 3'd3, 1'b1, 1'b0, -1);
    run_burst(BASE + 32'(8 * (DEPTH - 2)), 3, 2'b01, 3'd3, 1'b0, 1'b1, -1);
    run_burst(BASE, 1, 2'b10, 3'd3, 1'b1, 1'b0, -1);
    run_burst(BASE + 32'd3, 0, 2'b01, 3'd3, 1'b0, 1'b0, -1);
    run_burst(BASE - 32'd8, 1, 2'b01, 3'd3, 1'b1, 1'b0, -1);
    run_burst(BASE + 32'd16, 0, 2'b01, 3'd2, 1'b0, 1'b0, -1);
    run_burst(BASE, 63, 2'b01, 3'd3, 1'b1, 1'b0, 10);
    run_burst(BASE + 32'd56, 0, 2'b01, 3'd3, 1'b1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
